univ_shift_reg: RTL and testbench

//  Parametrised synchronous universal shift register; successor to the single-bit DFF cell.

---
 rtl/usr_pkg.sv | 15 +
 rtl/usr_cnt.sv | 42 ++++
 rtl/univ_shift_reg.sv | 77 +++++++
 tb/tb_univ_shift_reg.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// a width helper for the shift counter.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/usr_cnt.sv
// Saturating shift counter. Clear beats increment; done is registered and
// tracks whether the next count has reached MAX, so it holds while the count
// sits at saturation.
module usr_cnt
  import usr_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [cnt_w(MAX)-1:0]  cnt,
  output logic                   done
);

  localparam int CW = cnt_w(MAX);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_nxt;

  // Next count: clear on load, otherwise step up until pinned at MAX.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && (cnt != MAX_C))
      cnt_nxt = cnt + 1'b1;
  end

  // Counter and done flag registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      done <= (cnt_nxt == MAX_C);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a saturating shift counter that flags a fully shifted word.
// Build option ROTATE_EN: shifts recirculate the leaving bit instead of
// taking sin_r / sin_l.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      sin_r,
  input  logic                      sin_l,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          q,
  output logic                      sout_r,
  output logic                      sout_l,
  output logic [cnt_w(WIDTH)-1:0]   cnt,
  output logic                      done
);

  logic [WIDTH-1:0] q_nxt;
  logic             fill_r;  // bit entering q[WIDTH-1] on shift right
  logic             fill_l;  // bit entering q[0] on shift left
  logic             do_shift;
  logic             do_load;

`ifdef ROTATE_EN
  assign fill_r = q[0];
  assign fill_l = q[WIDTH-1];
  logic unused_sin;
  assign unused_sin = sin_r ^ sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  assign do_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign do_load  = en && (mode == MODE_LOAD);

  // Next-word mux; en low or hold mode keeps the current word.
  always_comb begin
    q_nxt = q;
    if (en) begin
      case (mode)
        MODE_SHR:  q_nxt = {fill_r, q[WIDTH-1:1]};
        MODE_SHL:  q_nxt = {q[WIDTH-2:0], fill_l};
        MODE_LOAD: q_nxt = d;
        default:   q_nxt = q;
      endcase
    end
  end

  // Word register; reset overrides any operation on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= RST_VAL;
    else
      q <= q_nxt;
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  usr_cnt #(.MAX(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (do_load),
    .inc   (do_shift),
    .cnt   (cnt),
    .done  (done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, RST_VAL=0): directed vector table,
// rotate sequence when ROTATE_EN is defined, and random traffic against a
// behavioural model.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n, en, sin_r, sin_l;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_r, sout_l;
  logic [3:0] cnt;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference model state: word value and number of shifts since load/reset.
  int m_q;
  int m_shifts;

  always #20 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .cnt(cnt), .done(done)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] d;
    logic [7:0] exp_q;
    int         exp_cnt;
    logic       exp_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rot_build();
`ifdef ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Model update from the rules: arithmetic on an integer word.
  task automatic model_step(input logic r, input logic e, input logic [1:0] m,
                            input logic sr, input logic sl, input logic [7:0] dd);
    int fill;
    if (!r) begin
      m_q = 0; m_shifts = 0;
    end else if (e) begin
      if (m == 2'd1) begin
        fill = rot_build() ? (m_q % 2) : int'(sr);
        m_q = (m_q / 2) + fill * 128;
        m_shifts = (m_shifts + 1 > W) ? W : m_shifts + 1;
      end else if (m == 2'd2) begin
        fill = rot_build() ? (m_q / 128) : int'(sl);
        m_q = ((m_q * 2) + fill) % 256;
        m_shifts = (m_shifts + 1 > W) ? W : m_shifts + 1;
      end else if (m == 2'd3) begin
        m_q = int'(dd); m_shifts = 0;
      end
    end
  endtask

  // Drive at negedge, take the rising edge, let outputs settle.
  task automatic apply(input logic r, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [7:0] dd);
    @(negedge clk);
    rst_n = r; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
    model_step(r, e, m, sr, sl, dd);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " q"},      int'(q),      m_q);
    chk({tag, " cnt"},    int'(cnt),    m_shifts);
    chk({tag, " done"},   int'(done),   (m_shifts == W) ? 1 : 0);
    chk({tag, " sout_r"}, int'(sout_r), m_q % 2);
    chk({tag, " sout_l"}, int'(sout_l), m_q / 128);
  endtask

  vec_t vt[$];

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; d = '0;
    m_q = 0; m_shifts = 0;

`ifndef ROTATE_EN
    // reset priority over load
    vt.push_back('{0,1,2'b11,0,0,8'hFF, 8'h00,0,0});
    vt.push_back('{0,1,2'b11,0,0,8'hFF, 8'h00,0,0});
    // load then disabled shifts hold
    vt.push_back('{1,1,2'b11,0,0,8'hA5, 8'hA5,0,0});
    vt.push_back('{1,0,2'b01,1,1,8'h00, 8'hA5,0,0});
    vt.push_back('{1,0,2'b01,1,1,8'h00, 8'hA5,0,0});
    vt.push_back('{1,0,2'b01,1,1,8'h00, 8'hA5,0,0});
    // 8x shift right of A5 plus one saturating shift
    vt.push_back('{1,1,2'b11,0,0,8'hA5, 8'hA5,0,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h52,1,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h29,2,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h14,3,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h0A,4,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h05,5,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h02,6,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h01,7,0});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h00,8,1});
    vt.push_back('{1,1,2'b01,0,1,8'h00, 8'h00,8,1});
    // shift left with sin_l=1, then reload clears count
    vt.push_back('{1,1,2'b11,0,0,8'h01, 8'h01,0,0});
    vt.push_back('{1,1,2'b10,0,1,8'h00, 8'h03,1,0});
    vt.push_back('{1,1,2'b10,0,1,8'h00, 8'h07,2,0});
    vt.push_back('{1,1,2'b10,0,1,8'h00, 8'h0F,3,0});
    vt.push_back('{1,1,2'b11,0,0,8'h3C, 8'h3C,0,0});
    // mid-shift reset, immediate load afterwards
    vt.push_back('{1,1,2'b11,0,0,8'h81, 8'h81,0,0});
    vt.push_back('{1,1,2'b01,0,0,8'h00, 8'h40,1,0});
    vt.push_back('{1,1,2'b01,0,0,8'h00, 8'h20,2,0});
    vt.push_back('{1,1,2'b01,0,0,8'h00, 8'h10,3,0});
    vt.push_back('{1,1,2'b01,0,0,8'h00, 8'h08,4,0});
    vt.push_back('{0,1,2'b01,1,1,8'hFF, 8'h00,0,0});
    vt.push_back('{1,1,2'b11,0,0,8'h5A, 8'h5A,0,0});
    // explicit hold mode with en=1, then shift right with sin_r=1
    vt.push_back('{1,1,2'b00,1,1,8'hFF, 8'h5A,0,0});
    vt.push_back('{1,1,2'b01,1,0,8'h00, 8'hAD,1,0});
    // mixed directions count together
    vt.push_back('{1,1,2'b10,0,0,8'h00, 8'h5A,2,0});

    foreach (vt[i]) begin
      apply(vt[i].rst_n, vt[i].en, vt[i].mode, vt[i].sin_r, vt[i].sin_l, vt[i].d);
      chk($sformatf("vec%0d q", i),      int'(q),      int'(vt[i].exp_q));
      chk($sformatf("vec%0d cnt", i),    int'(cnt),    vt[i].exp_cnt);
      chk($sformatf("vec%0d done", i),   int'(done),   int'(vt[i].exp_done));
      chk($sformatf("vec%0d sout_r", i), int'(sout_r), int'(vt[i].exp_q[0]));
      chk($sformatf("vec%0d sout_l", i), int'(sout_l), int'(vt[i].exp_q[7]));
    end
`else
    // rotate build: full rotation of 81 returns to 81 with done set
    apply(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    chk("rot reset q", int'(q), 0);
    apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
    apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    chk("rot first q", int'(q), 8'hC0);
    chk("rot first cnt", int'(cnt), 1);
    for (int k = 0; k < 7; k++) begin
      apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
      chk("rot done early", int'(done), (k == 6) ? 1 : 0);
    end
    chk("rot full q", int'(q), 8'h81);
    chk("rot full cnt", int'(cnt), 8);
    chk("rot full done", int'(done), 1);
    apply(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 8'h00);
    chk("rot left q", int'(q), 8'h03);
    chk("rot left cnt", int'(cnt), 8);
`endif

    // random traffic against the model
    apply(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    chk_model("rnd rst");
    for (int n = 0; n < 400; n++) begin
      logic r;
      logic [1:0] m;
      r = ($urandom_range(0, 24) != 0);
      m = 2'($urandom_range(0, 3));
      // bias toward shifts so saturation is reached regularly
      if ($urandom_range(0, 3) == 0 && m == 2'b11) m = 2'b01;
      apply(r, ($urandom_range(0, 7) != 0), m, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
